ysyx_25030093_mem_arbiter: RTL
==============================

# ysyx_25030093_mem_arbiter

Parametrised N-channel arbiter that merges the core's independent memory request channels (instruction fetch, load/store, and later DMA or debug masters) onto one downstream memory port. It uses the core's existing level-held valid/respValid protocol and serves one transaction at a time. It sits between the core's request ports and the SoC memory model or bridge, so the IFU and LSU no longer need separate memory paths.

## Interface
Parameters:
- NCH, 2, number of upstream channels (1..16); channel 0 is highest fixed priority
- AW, 32, address width
- DW, 32, data width (multiple of 8); mask width MW = DW/8

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NCH  per-channel request, level-held until that channel's resp_valid
- req_addr  in  NCH*AW  packed addresses, channel i at [i*AW +: AW]
- req_size  in  NCH*2  packed size codes (0=byte, 1=half, 2=word)
- req_wen  in  NCH  1 = write
- req_wdata  in  NCH*DW  packed write data
- req_wmask  in  NCH*MW  packed byte masks
- resp_valid  out  NCH  one-cycle completion pulse; at most one bit high
- resp_rdata  out  DW  read data, shared by all channels, valid with resp_valid
- grant_id  out  max(1,$clog2(NCH))  index of the channel being served (debug)
- busy  out  1  high in BUSY and RESP
- mem_reqValid  out  1  downstream request, held until mem_respValid
- mem_addr / mem_size / mem_wen / mem_wdata / mem_wmask  out  AW/2/1/DW/MW  latched payload of the granted channel
- mem_respValid  in  1  downstream completion
- mem_rdata  in  DW  downstream read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - If any req_valid is high, choose a winner: fixed priority or round-robin (see Configuration).
  - At the clock edge, latch the winner's payload into the mem_* registers, set grant_id, set mem_reqValid=1, and go to BUSY.
- BUSY
  - mem_reqValid and the mem_* payload stay stable.
  - On mem_respValid=1: capture mem_rdata into resp_rdata, set resp_valid[grant_id]=1, clear mem_reqValid, and go to RESP.
- RESP
  - resp_valid is high for this single cycle.
  - Next state is IDLE unconditionally.
- Clients update req_valid from registered state only. A client that sees resp_valid at an edge may present a new request from the following cycle; that new request is legal in the IDLE cycle.
- mem_respValid in IDLE or RESP is spurious and is ignored: no resp_valid and no state change.
- If req_valid drops while BUSY (protocol violation), the transaction still completes and the response is delivered.
- Writes also capture mem_rdata; its value is don't-care for writes.
- Non-granted channels get no response and are not stalled in any other way; they simply keep req_valid held.

## Timing
- Reset (asynchronous assert, synchronous release)
  - State = IDLE.
  - Outputs = 0: mem_reqValid, resp_valid, mem_* payload, resp_rdata, grant_id, busy.
  - Round-robin pointer = 0.
- Reset asserted mid-transaction: the transaction is abandoned, mem_reqValid drops immediately, and no resp_valid is issued.
- Request latency: req_valid sampled high in IDLE at edge k gives mem_reqValid=1 from cycle k+1.
- Response latency: mem_respValid sampled at edge m gives resp_valid from cycle m+1 for exactly one cycle.
- Minimum occupancy is 3 cycles per transaction: IDLE, BUSY (with zero-latency memory), RESP.
- Throughput: one transaction per 3 cycles at best.
- Outputs are registered; there are no combinational paths from req_* or mem_respValid to outputs.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - The winner is the first requesting channel at or after the pointer, searching upward and wrapping modulo NCH.
  - On grant, pointer = winner+1 (mod NCH, so NCH-1 wraps to 0).
- ARB_RR_EN undefined: fixed priority, lowest requesting index wins; no pointer register exists.
- NCH=1 behaves identically in both modes.

## Test plan
- Single read, NCH=2, zero-latency memory: ch1 read 0x8000_0004 with mem_rdata=0xDEADBEEF.
  - mem_reqValid the cycle after the request, with mem_addr=0x8000_0004.
  - resp_valid=2'b10 for one cycle; resp_rdata=0xDEADBEEF.
- Simultaneous requests, ch0 write (wdata 0x1234_5678, wmask 0xF) and ch1 read, memory latency 3.
  - ch0 is served first in both modes; ch1 is served next.
  - Exactly two resp_valid pulses, never overlapping.
- Starvation, ARB_RR_EN defined, NCH=3: all channels request continuously.
  - Grant order is 0,1,2,0,1,2.
  - Without ARB_RR_EN, ch0 wins every arbitration.
- Spurious responses: mem_respValid pulsed while IDLE, and again in RESP.
  - No resp_valid, busy stays as per state, FSM unchanged.
- Reset mid-transaction: reset low in BUSY.
  - mem_reqValid=0 immediately; no resp_valid after release.
  - First post-reset request of ch1 completes normally; in RR mode the pointer is back at 0.

Source files
------------

// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Bundles the upstream request/response channels and the downstream memory port of the mem arbiter.
// "master" is the client/memory environment side; "slave" is the arbiter side.
interface ysyx_25030093_mem_arbiter_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    localparam int MW = DW / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]    req_valid;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*2-1:0]  req_size;
    logic [NCH-1:0]    req_wen;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH*MW-1:0] req_wmask;
    logic [NCH-1:0]    resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic [GW-1:0]     grant_id;
    logic              busy;

    logic              mem_reqValid;
    logic [AW-1:0]     mem_addr;
    logic [1:0]        mem_size;
    logic              mem_wen;
    logic [DW-1:0]     mem_wdata;
    logic [MW-1:0]     mem_wmask;
    logic              mem_respValid;
    logic [DW-1:0]     mem_rdata;

    modport master (
        output req_valid, req_addr, req_size, req_wen, req_wdata, req_wmask,
        input  resp_valid, resp_rdata, grant_id, busy,
        input  mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        output mem_respValid, mem_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_wen, req_wdata, req_wmask,
        output resp_valid, resp_rdata, grant_id, busy,
        output mem_reqValid, mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask,
        input  mem_respValid, mem_rdata
    );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// N-channel memory arbiter: one transaction at a time through IDLE -> BUSY -> RESP, all outputs registered.
// Define ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting channel index wins.
module ysyx_25030093_mem_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_25030093_mem_arbiter_if.slave bus
);
    localparam int MW = DW / 8;
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state_r;
    logic [1:0]     state_nx_s;
    logic           any_req_s;
    logic           hit_s;
    logic [GW-1:0]  win_s;
    logic [NCH-1:0] onehot_s;

    logic           mem_req_valid_r;
    logic [AW-1:0]  mem_addr_r;
    logic [1:0]     mem_size_r;
    logic           mem_wen_r;
    logic [DW-1:0]  mem_wdata_r;
    logic [MW-1:0]  mem_wmask_r;
    logic [NCH-1:0] resp_valid_r;
    logic [DW-1:0]  resp_rdata_r;
    logic [GW-1:0]  grant_id_r;
    logic           busy_r;

`ifdef ARB_RR_EN
    logic [GW-1:0]  rr_ptr_r;
    logic [5:0]     idx_s;

    // Round-robin winner: first requester at or after the pointer, wrapping modulo NCH.
    always_comb begin
        any_req_s = 1'b0;
        hit_s     = 1'b0;
        win_s     = '0;
        idx_s     = 6'd0;
        for (int i = 0; i < NCH; i++) begin
            idx_s     = 6'(rr_ptr_r) + 6'(i);
            idx_s     = (idx_s >= 6'(NCH)) ? (idx_s - 6'(NCH)) : idx_s;
            hit_s     = bus.req_valid[GW'(idx_s)] & ~any_req_s;
            win_s     = hit_s ? GW'(idx_s) : win_s;
            any_req_s = any_req_s | hit_s;
        end
    end

    // Pointer moves just past the winner on every grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= '0;
        end else if ((state_r == IDLE) && any_req_s) begin
            rr_ptr_r <= (win_s == GW'(NCH - 1)) ? '0 : GW'(win_s + 1'b1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    // Fixed-priority winner: lowest requesting index.
    always_comb begin
        any_req_s = 1'b0;
        hit_s     = 1'b0;
        win_s     = '0;
        for (int i = 0; i < NCH; i++) begin
            hit_s     = bus.req_valid[i] & ~any_req_s;
            win_s     = hit_s ? GW'(i) : win_s;
            any_req_s = any_req_s | hit_s;
        end
    end
`endif

    // Next-state logic; memory responses outside BUSY are ignored.
    always_comb begin
        state_nx_s = IDLE;
        case (state_r)
            IDLE:    state_nx_s = any_req_s ? BUSY : IDLE;
            BUSY:    state_nx_s = bus.mem_respValid ? RESP : BUSY;
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // One-hot response vector for the channel currently being served.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NCH; i++) begin
            onehot_s[i] = (grant_id_r == GW'(i));
        end
    end

    // FSM, payload latch and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            busy_r          <= 1'b0;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= '0;
            mem_size_r      <= 2'd0;
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= '0;
            mem_wmask_r     <= '0;
            resp_valid_r    <= '0;
            resp_rdata_r    <= '0;
            grant_id_r      <= '0;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != IDLE);
            resp_valid_r <= '0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        mem_req_valid_r <= 1'b1;
                        grant_id_r      <= win_s;
                        mem_addr_r      <= bus.req_addr[int'(win_s) * AW +: AW];
                        mem_size_r      <= bus.req_size[int'(win_s) * 2 +: 2];
                        mem_wen_r       <= bus.req_wen[win_s];
                        mem_wdata_r     <= bus.req_wdata[int'(win_s) * DW +: DW];
                        mem_wmask_r     <= bus.req_wmask[int'(win_s) * MW +: MW];
                    end else begin
                        mem_req_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus.mem_respValid) begin
                        mem_req_valid_r <= 1'b0;
                        resp_valid_r    <= onehot_s;
                        resp_rdata_r    <= bus.mem_rdata;
                    end else begin
                        mem_req_valid_r <= 1'b1;
                    end
                end
                default: begin
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_reqValid = mem_req_valid_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_size     = mem_size_r;
    assign bus.mem_wen      = mem_wen_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.mem_wmask    = mem_wmask_r;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_rdata   = resp_rdata_r;
    assign bus.grant_id     = grant_id_r;
    assign bus.busy         = busy_r;
endmodule
